// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit-word to 16-bit SRAM sequencer.
package sram_controller_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int          DEF_ADDR_W    = 18;
  localparam int          DEF_DQ_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_LO = 3'd1,
    ST_WR_HI = 3'd2,
    ST_RD_LO = 3'd3,
    ST_RD_HI = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two halfword SRAM cycles and
// holds ready low so the pipeline freezes until the word is complete.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          DQ_W      = DEF_DQ_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [2*DQ_W-1:0]   write_data,
  output logic [2*DQ_W-1:0]   read_data,
  output logic                ready,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [DQ_W-1:0]     SRAM_DQ,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  state_e              state_r;
  state_e              next_state_s;
  logic [ADDR_W:0]     rel_addr_s;
  logic [ADDR_W-2:0]   word_idx_s;
  logic [ADDR_W-1:0]   addr_lo_s;
  logic [ADDR_W-1:0]   addr_hi_s;
  logic [ADDR_W-1:0]   sram_addr_s;
  logic [DQ_W-1:0]     dq_out_s;
  logic                we_n_s;
  logic [DQ_W-1:0]     lo_r;
  logic [DQ_W-1:0]     hi_r;
  logic                unused_bits_s;

  // Only the low ADDR_W+1 bits of the offset reach the SRAM, so the
  // subtraction is done at that width (identical to the full mod-2^32 result).
  assign rel_addr_s    = address[ADDR_W:0] - BASE_ADDR[ADDR_W:0];
  assign word_idx_s    = rel_addr_s[ADDR_W:2];
  assign addr_lo_s     = {word_idx_s, 1'b0};
  assign addr_hi_s     = {word_idx_s, 1'b1};
  assign unused_bits_s = ^{address[31:ADDR_W+1], rel_addr_s[1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and SRAM pin decode.
  always_comb begin
    next_state_s = state_r;
    we_n_s       = 1'b1;
    sram_addr_s  = {ADDR_W{1'b0}};
    dq_out_s     = {DQ_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (wr_en) begin
          next_state_s = ST_WR_LO;
        end else if (rd_en) begin
          next_state_s = ST_RD_LO;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WR_LO: begin
        we_n_s       = 1'b0;
        sram_addr_s  = addr_lo_s;
        dq_out_s     = write_data[DQ_W-1:0];
        next_state_s = ST_WR_HI;
      end
      ST_WR_HI: begin
        we_n_s       = 1'b0;
        sram_addr_s  = addr_hi_s;
        dq_out_s     = write_data[2*DQ_W-1:DQ_W];
        next_state_s = ST_DONE;
      end
      ST_RD_LO: begin
        sram_addr_s  = addr_lo_s;
        next_state_s = ST_RD_HI;
      end
      ST_RD_HI: begin
        sram_addr_s  = addr_hi_s;
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Read capture: async SRAM data has settled by the edge that leaves each read state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_r <= {DQ_W{1'b0}};
      hi_r <= {DQ_W{1'b0}};
    end else begin
      case (state_r)
        ST_RD_LO: lo_r <= SRAM_DQ;
        ST_RD_HI: hi_r <= SRAM_DQ;
        default: begin
          lo_r <= lo_r;
          hi_r <= hi_r;
        end
      endcase
    end
  end

  assign SRAM_DQ   = we_n_s ? {DQ_W{1'bz}} : dq_out_s;
  assign SRAM_WE_N = we_n_s;
  assign SRAM_ADDR = sram_addr_s;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = {hi_r, lo_r};
  assign ready     = ((state_r == ST_IDLE) && !wr_en && !rd_en) || (state_r == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural async SRAM model.
module tb_sram_controller;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [17:0] lo_addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  logic [15:0] mem [0:262143];
  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  int          busy = 0;
  int          we_low = 0;
  logic [17:0] seen_lo = 18'd0;
  logic [17:0] seen_hi = 18'd0;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
  );

  always #5 clk = ~clk;

  // Asynchronous-read SRAM: drives the bus whenever selected and not written.
  assign sram_dq = (sram_we_n && !sram_oe_n && !sram_ce_n) ? mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (!sram_we_n && !sram_ce_n) mem[sram_addr] <= sram_dq;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: tracks each busy window and scores it when ready returns with a request held.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy = 0;
      we_low = 0;
    end else if (!ready) begin
      if (busy == 1) seen_lo = sram_addr;
      if (busy == 2) seen_hi = sram_addr;
      if (!sram_we_n) we_low++;
      busy++;
    end else if (wr_en || rd_en) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_completion: got a completion expected none");
      end else begin
        e = exp_q.pop_front();
        chk("latency", busy, 32'd3);
        chk("addr_lo", {14'd0, seen_lo}, {14'd0, e.lo_addr});
        chk("addr_hi", {14'd0, seen_hi}, {14'd0, e.lo_addr + 18'd1});
        chk("we_cycles", we_low, e.is_rd ? 32'd0 : 32'd2);
        if (e.is_rd) begin
          chk("read_data", read_data, e.data);
        end else begin
          chk("mem_lo", {16'd0, mem[e.lo_addr]}, {16'd0, e.data[15:0]});
          chk("mem_hi", {16'd0, mem[e.lo_addr + 18'd1]}, {16'd0, e.data[31:16]});
        end
      end
      busy = 0;
      we_low = 0;
    end else begin
      busy = 0;
      we_low = 0;
    end
  end

  // Drive one request (called just after a rising edge in IDLE) and wait for ready.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit hold);
    exp_t e;
    bit   seen = 1'b0;
    e.is_rd   = !wr;
    e.data    = d;
    e.lo_addr = {a[18:2] - 17'd256, 1'b0};
    exp_q.push_back(e);
    wr_en = wr;
    rd_en = rd;
    address = a;
    write_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_ties", {28'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0);
    access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0);
    access(1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0);
    access(1'b1, 1'b0, 32'd1036, 32'h77776666, 1'b0);

    // Abort a write during WR_HI: only the low half may land.
    wr_en = 1'b1;
    address = 32'd1036;
    write_data = 32'h11112222;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("arst_read_data", read_data, 32'd0);
    chk("arst_addr", {14'd0, sram_addr}, 32'd0);
    chk("arst_ready_req", {31'd0, ready}, 32'd0);
    wr_en = 1'b0;
    #1;
    chk("arst_ready_idle", {31'd0, ready}, 32'd1);
    chk("arst_mem_lo", {16'd0, mem[18'd6]}, 32'h00002222);
    chk("arst_mem_hi", {16'd0, mem[18'd7]}, 32'h00007777);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 32'd1036, 32'h77772222, 1'b0);

    // Back-to-back: read held across the IDLE that follows DONE.
    access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, 1'b1);
    access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b1);
    access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("completions", n_done, 32'd11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the board's 16-bit asynchronous-read SRAM chip for the pipeline's MEM stage.
- Converts one 32-bit word read or write into two consecutive 16-bit SRAM accesses.
- Drives `ready` low while busy so the hazard/freeze logic stalls the pipeline.
- Sits between the MEM stage and the SRAM pins.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory start; subtracted before mapping to SRAM.
- ADDR_W, 18: SRAM address width.
- DQ_W, 16: SRAM data width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- wr_en  in  1  word write request; held by pipeline until ready.
- rd_en  in  1  word read request; held by pipeline until ready.
- address  in  32  byte address, word aligned.
- write_data  in  32  write word.
- read_data  out  32  read word, valid while ready=1 after a read.
- ready  out  1  1 = no pending access / access complete; 0 = freeze pipeline.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_WE_N  out  1  write enable, active-low.
- SRAM_UB_N  out  1  upper byte enable, active-low.
- SRAM_LB_N  out  1  lower byte enable, active-low.
- SRAM_CE_N  out  1  chip enable, active-low.
- SRAM_OE_N  out  1  output enable, active-low.

Behaviour:
- Address map:
  - a = address - BASE_ADDR, unsigned, wraps mod 2^32.
  - Low half at {a[18:2],1'b0}; high half at {a[18:2],1'b1}.
  - a[1:0] ignored.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- IDLE:
  - wr_en=1 -> WR_LO; else rd_en=1 -> RD_LO; else stay.
  - wr_en and rd_en both 1: write wins.
- WR_LO: SRAM_WE_N=0, SRAM_ADDR=low, DQ driven write_data[15:0] -> WR_HI.
- WR_HI: SRAM_WE_N=0, SRAM_ADDR=high, DQ driven write_data[31:16] -> DONE.
- RD_LO: SRAM_WE_N=1, DQ released (Z), SRAM_ADDR=low; lo_reg <= SRAM_DQ at cycle end -> RD_HI.
- RD_HI: as RD_LO with high address; hi_reg <= SRAM_DQ -> DONE.
- DONE: ready=1 for exactly one cycle -> IDLE unconditionally.
- read_data = {hi_reg, lo_reg}; holds until next read capture.
- ready (combinational) = (IDLE and !wr_en and !rd_en) or DONE.
- Latency: request seen in cycle 0 -> ready=1 in cycle 3. Pipeline advances on that edge.
- A request still asserted in the IDLE after DONE is treated as new (back-to-back accesses take 4 cycles each).
- SRAM_WE_N=0 only in WR_LO/WR_HI.
- SRAM_DQ driven only when SRAM_WE_N=0, else Z.
- SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N tied 0.
- SRAM_ADDR=0 in IDLE/DONE.
- Inputs must be stable while ready=0; the controller does not latch them.
- SRAM read data settles within 5 ns, which is less than the clock period; capture is on the same edge that leaves the state.
- Reset (rst=0, any time):
  - State -> IDLE, SRAM_WE_N=1 immediately, DQ Z, lo_reg=hi_reg=0, read_data=0.
  - ready then follows the IDLE equation.
  - Reset mid-write may leave only the low half written; this is acceptable.

Decomposition:
- Shared package: state enumeration (3-bit encoding), BASE_ADDR default, SRAM width constants.
- No sub-module; the FSM plus capture registers is one module.
- Tristate driver is a single continuous assignment.

Test Plan:
- Write 0xDEADBEEF at 1024 -> memory[0]=0xBEEF, memory[1]=0xDEAD; ready low cycles 0–2, high cycle 3; WE_N low exactly 2 cycles.
- Read 1024 after the above -> read_data=0xDEADBEEF at cycle 3; WE_N stays 1; DQ never driven by controller.
- Write 0x12345678 at 1028 -> SRAM_ADDR 2 then 3; memory[2]=0x5678, memory[3]=0x1234; read back matches.
- wr_en=rd_en=1, address 1032, data 0xA5A5_5A5A -> write path taken (WR_LO/WR_HI); memory[4]=0x5A5A, memory[5]=0xA5A5.
- rst pulled low during WR_HI -> SRAM_WE_N=1 asynchronously, state IDLE, read_data=0, DQ=Z; memory[high] unchanged.
- Back-to-back: write 1024, then read 1024 held continuously -> second access begins in the IDLE after DONE; read_data=written value 4 cycles later; no request dropped or duplicated.
